// File: rtl/reg_rename.sv
// Register rename stage for a 2-wide in-order front end.
// It holds a RAT, a free-list FIFO and a FIFO of displaced mappings that commit returns to the free list.
module reg_rename #(
    parameter int AR_W  = 3,
    parameter int PR_W  = 4,
    parameter int NFREE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            V1,
    input  logic [AR_W-1:0] ArD1,
    input  logic [AR_W-1:0] ArS1a,
    input  logic [AR_W-1:0] ArS1b,
    input  logic            V2,
    input  logic [AR_W-1:0] ArD2,
    input  logic [AR_W-1:0] ArS2a,
    input  logic [AR_W-1:0] ArS2b,
    input  logic [1:0]      CmtCount,
    input  logic            stallRR,
    output logic [PR_W-1:0] PrD1,
    output logic [PR_W-1:0] PrS1a,
    output logic [PR_W-1:0] PrS1b,
    output logic [PR_W-1:0] PrD2,
    output logic [PR_W-1:0] PrS2a,
    output logic [PR_W-1:0] PrS2b,
    output logic            RRStalled
);

    localparam int NARCH = 1 << AR_W;
    localparam int PTR_W = $clog2(NFREE);
    localparam int CNT_W = PTR_W + 1;

    logic [PR_W-1:0]  rat_q [NARCH];
    logic [PR_W-1:0]  fl_q  [NFREE];
    logic [PR_W-1:0]  dq_q  [NFREE];
    logic [PTR_W-1:0] fl_head_q, fl_tail_q, dq_head_q, dq_tail_q;
    logic [CNT_W-1:0] fl_cnt_q;

    logic [PTR_W-1:0] fl_head_d, fl_tail_d, dq_head_d, dq_tail_d;
    logic [CNT_W-1:0] fl_cnt_d;

    logic [PR_W-1:0]  head0, head1, pd2_raw, push0, push1;
    logic [1:0]       need, alloc_n, cmt_n;
    logic [CNT_W-1:0] dq_cnt;
    logic             stall_c, accept;

    always_comb begin
        head0   = fl_q[fl_head_q];
        head1   = fl_q[fl_head_q + PTR_W'(1)];
        pd2_raw = V1 ? head1 : head0;
        need    = {1'b0, V1} + {1'b0, V2};
        stall_c = stallRR || (fl_cnt_q < CNT_W'(need));
        accept  = !reset && !stall_c && (need != 2'd0);
        alloc_n = accept ? need : 2'd0;

        // Slot 2 displaces slot 1's fresh register when both write the same arch reg.
        push0 = rat_q[ArD1];
        push1 = (V1 && (ArD2 == ArD1)) ? head0 : rat_q[ArD2];

        dq_cnt = CNT_W'(NFREE) - fl_cnt_q;
        if (CNT_W'(CmtCount) > dq_cnt) cmt_n = dq_cnt[1:0];
        else                           cmt_n = CmtCount;

        fl_head_d = fl_head_q + PTR_W'(alloc_n);
        dq_tail_d = dq_tail_q + PTR_W'(alloc_n);
        fl_tail_d = fl_tail_q + PTR_W'(cmt_n);
        dq_head_d = dq_head_q + PTR_W'(cmt_n);
        fl_cnt_d  = fl_cnt_q + CNT_W'(cmt_n) - CNT_W'(alloc_n);
    end

    always_comb begin
        PrD1      = '0;
        PrD2      = '0;
        PrS1a     = '0;
        PrS1b     = '0;
        PrS2a     = '0;
        PrS2b     = '0;
        RRStalled = 1'b1;
        if (!reset) begin
            PrD1      = V1 ? head0 : '0;
            PrD2      = V2 ? pd2_raw : '0;
            PrS1a     = rat_q[ArS1a];
            PrS1b     = rat_q[ArS1b];
            PrS2a     = (V1 && (ArS2a == ArD1)) ? head0 : rat_q[ArS2a];
            PrS2b     = (V1 && (ArS2b == ArD1)) ? head0 : rat_q[ArS2b];
            RRStalled = stall_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NARCH; i++) rat_q[i] <= PR_W'(i);
            for (int i = 0; i < NFREE; i++) fl_q[i] <= PR_W'(NARCH + i);
            fl_head_q <= '0;
            fl_tail_q <= '0;
            dq_head_q <= '0;
            dq_tail_q <= '0;
            fl_cnt_q  <= CNT_W'(NFREE);
        end else begin
            // NOTE: non-blocking writes resolve last-wins, so slot 2 overrides slot 1 on equal ArD.
            if (accept && V1) rat_q[ArD1] <= head0;
            if (accept && V2) rat_q[ArD2] <= pd2_raw;
            for (int i = 0; i < 3; i++) begin
                if (i < int'(cmt_n)) fl_q[fl_tail_q + PTR_W'(i)] <= dq_q[dq_head_q + PTR_W'(i)];
            end
            fl_head_q <= fl_head_d;
            fl_tail_q <= fl_tail_d;
            dq_head_q <= dq_head_d;
            dq_tail_q <= dq_tail_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only read after being pushed, so pointers alone define validity.
    always_ff @(posedge clk) begin
        if (accept && V1) dq_q[dq_tail_q] <= push0;
        if (accept && V2) dq_q[dq_tail_q + PTR_W'(V1)] <= push1;
    end

endmodule

// File: tb/tb_reg_rename.sv
// Self-checking bench for reg_rename: hand-derived vector table plus multi-cycle corner sequences.
module tb_reg_rename;

    logic       clk = 1'b0;
    logic       reset;
    logic       V1, V2, stallRR;
    logic [2:0] ArD1, ArS1a, ArS1b, ArD2, ArS2a, ArS2b;
    logic [1:0] CmtCount;
    logic [3:0] PrD1, PrS1a, PrS1b, PrD2, PrS2a, PrS2b;
    logic       RRStalled;

    always #5 clk = ~clk;

    reg_rename dut (
        .clk(clk), .reset(reset),
        .V1(V1), .ArD1(ArD1), .ArS1a(ArS1a), .ArS1b(ArS1b),
        .V2(V2), .ArD2(ArD2), .ArS2a(ArS2a), .ArS2b(ArS2b),
        .CmtCount(CmtCount), .stallRR(stallRR),
        .PrD1(PrD1), .PrS1a(PrS1a), .PrS1b(PrS1b),
        .PrD2(PrD2), .PrS2a(PrS2a), .PrS2b(PrS2b),
        .RRStalled(RRStalled)
    );

    typedef struct {
        logic       v1;
        logic [2:0] d1, s1a, s1b;
        logic       v2;
        logic [2:0] d2, s2a, s2b;
        logic [1:0] cmt;
        logic       stall;
        logic       pd_dc;   // destination fields are stale (free list short) and not compared
        logic [3:0] pd1, ps1a, ps1b, pd2, ps2a, ps2b;
        logic       stl;
    } vec_t;

    typedef struct {
        int          id;
        logic [24:0] exp;
        logic [24:0] mask;
    } sb_t;

    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[15];

    function automatic vec_t mk(input int f[18]);
        vec_t v;
        v.v1 = f[0][0];  v.d1 = 3'(f[1]);  v.s1a = 3'(f[2]);  v.s1b = 3'(f[3]);
        v.v2 = f[4][0];  v.d2 = 3'(f[5]);  v.s2a = 3'(f[6]);  v.s2b = 3'(f[7]);
        v.cmt = 2'(f[8]); v.stall = f[9][0]; v.pd_dc = f[10][0];
        v.pd1 = 4'(f[11]); v.ps1a = 4'(f[12]); v.ps1b = 4'(f[13]);
        v.pd2 = 4'(f[14]); v.ps2a = 4'(f[15]); v.ps2b = 4'(f[16]);
        v.stl = f[17][0];
        return v;
    endfunction

    task automatic drive(input vec_t v, input int id);
        sb_t e;
        V1 = v.v1; ArD1 = v.d1; ArS1a = v.s1a; ArS1b = v.s1b;
        V2 = v.v2; ArD2 = v.d2; ArS2a = v.s2a; ArS2b = v.s2b;
        CmtCount = v.cmt; stallRR = v.stall;
        e.id   = id;
        e.exp  = {v.pd1, v.ps1a, v.ps1b, v.pd2, v.ps2a, v.ps2b, v.stl};
        e.mask = v.pd_dc ? {4'h0, 8'hFF, 4'h0, 8'hFF, 1'b1} : '1;
        sb_q.push_back(e);
    endtask

    task automatic check();
        sb_t         e;
        logic [24:0] act;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got output with no expected entry");
        end else begin
            e   = sb_q.pop_front();
            act = {PrD1, PrS1a, PrS1b, PrD2, PrS2a, PrS2b, RRStalled};
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_bad++;
                $display("FAIL vec%0d: got {D1,S1a,S1b,D2,S2a,S2b,stl}=%h expected %h (mask %h)",
                         e.id, act, e.exp, e.mask);
            end
        end
    endtask

    // Drive just after a rising edge, compare on the falling edge, then advance through the next edge.
    task automatic step(input vec_t v, input int id);
        drive(v, id);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   last;

        //                v1 d1 s1a s1b v2 d2 s2a s2b cmt st dc  pd1 ps1a ps1b pd2 ps2a ps2b stl
        tbl[0]  = mk('{1, 1, 2, 3,  0, 0, 0, 0,  0, 0, 0,  8,  2,  3,  0,  0,  0, 0});
        tbl[1]  = mk('{1, 4, 1, 0,  0, 0, 1, 4,  0, 0, 0,  9,  8,  0,  0,  8,  9, 0});
        tbl[2]  = mk('{1, 5, 4, 1,  1, 5, 5, 4,  0, 0, 0, 10,  9,  8, 11, 10,  9, 0});
        tbl[3]  = mk('{0, 0, 5, 4,  1, 2, 5, 1,  2, 0, 0,  0, 11,  9, 12, 11,  8, 0});
        tbl[4]  = mk('{1, 3, 2, 3,  1, 3, 3, 2,  0, 0, 0, 13, 12,  3, 14, 13, 12, 0});
        tbl[5]  = mk('{1, 6, 3, 5,  0, 0, 6, 7,  1, 1, 0, 15, 14, 11,  0, 15,  7, 1});
        tbl[6]  = mk('{1, 6, 3, 5,  0, 0, 6, 7,  0, 0, 0, 15, 14, 11,  0, 15,  7, 0});
        tbl[7]  = mk('{1, 7, 6, 0,  1, 0, 7, 6,  3, 0, 0,  1, 15,  0,  4,  1, 15, 0});
        tbl[8]  = mk('{1, 1, 7, 0,  1, 2, 1, 0,  0, 0, 0,  5,  1,  4, 10,  5,  4, 0});
        tbl[9]  = mk('{1, 4, 1, 2,  1, 5, 3, 4,  0, 0, 0,  2,  5, 10,  3, 14,  2, 0});
        tbl[10] = mk('{1, 6, 4, 5,  0, 0, 7, 0,  1, 0, 1,  0,  2,  3,  0,  1,  4, 1});
        tbl[11] = mk('{1, 6, 4, 5,  0, 0, 7, 0,  0, 0, 0, 13,  2,  3,  0,  1,  4, 0});
        tbl[12] = mk('{0, 0, 6, 7,  0, 0, 6, 5,  1, 0, 0,  0, 13,  1,  0, 13,  3, 0});
        tbl[13] = mk('{1, 0, 0, 1,  1, 1, 2, 1,  0, 0, 1,  0,  4,  5,  0, 10,  5, 1});
        tbl[14] = mk('{1, 0, 0, 1,  0, 1, 2, 1,  0, 0, 0,  6,  4,  5,  0, 10,  5, 0});

        reset = 1'b1;
        drive(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}), 100);
        void'(sb_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        // Outputs held at zero with RRStalled=1 while reset is asserted.
        step(mk('{1, 1, 2, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}), 101);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) step(tbl[i], i);

        // Mid-operation reset restores identity RAT and the 8..15 free list.
        reset = 1'b1;
        step(mk('{1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}), 200);
        reset = 1'b0;
        step(mk('{1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 8, 1, 4, 0, 0, 0, 0}), 201);

        // Over-commit: CmtCount=3 with one displaced entry frees exactly one register.
        step(mk('{0, 0, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0, 8, 8, 0, 8, 8, 0}), 202);

        // Eight single renames drain 9..15 then the recycled 1; the ninth must stall.
        last = 2;
        for (int k = 0; k < 8; k++) begin
            v = mk('{1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0});
            v.pd1  = (k < 7) ? 4'(9 + k) : 4'd1;
            v.ps1b = 4'(last);
            step(v, 300 + k);
            last = int'(v.pd1);
        end
        v = mk('{1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, 1});
        v.ps1b = 4'(last);
        step(v, 308);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
